// File: rtl/ksa_scrambler.sv
// ksa_scrambler
// -------------
// Runs the RC4 key-scheduling algorithm (KSA) over an external single-port
// RAM holding the permutation table s[0..DEPTH-1]:
//   j = 0
//   for i in 0..DEPTH-1:
//     j = (j + s[i] + key[i mod KEY_BYTES]) mod DEPTH
//     swap(s[i], s[j])
// It can optionally fill the table with the identity permutation first.
// The RAM has one cycle of read latency: the address is held for two
// cycles and q is captured at the end of the second one.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   start       begin a run; only looked at in IDLE
//   init_en     when 1 at the accepting start edge, write s[a]=a first
//   secret_key  KEY_BYTES bytes, byte 0 in the most significant position
//   q           RAM read data
//   busy        high in every state except IDLE
//   done        one-cycle pulse when the run completes
//   wren        RAM write enable
//   address     RAM address
//   data        RAM write data
//   state_dbg   current FSM state encoding (observation only)
//
// Handshake: start is a level request sampled only while IDLE. The edge on
// which IDLE sees start=1 is the accepting edge: key and init_en are latched
// there and busy rises. start is ignored while busy. done pulses for exactly
// one cycle, after which the block returns to IDLE; if start is still high
// in IDLE, a new run is accepted on that edge.

module ksa_scrambler #(
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   init_en,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  input  logic [DATA_W-1:0]      q,
  output logic                   busy,
  output logic                   done,
  output logic                   wren,
  output logic [DATA_W-1:0]      address,
  output logic [DATA_W-1:0]      data,
  output logic [3:0]             state_dbg
);

  // Key-index counter width; at least one bit even for a one-byte key.
  localparam int KIW    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  // Key byte lookup table padded to a power of two so any counter value
  // selects a defined entry.
  localparam int KSLOTS = 1 << KIW;

  localparam logic [KIW-1:0]    KIDX_LAST = KIW'(KEY_BYTES - 1);
  localparam logic [DATA_W-1:0] I_LAST    = '1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INIT_WR = 4'd1,
    S_RD_I1   = 4'd2,
    S_RD_I2   = 4'd3,
    S_CALC_J  = 4'd4,
    S_RD_J1   = 4'd5,
    S_RD_J2   = 4'd6,
    S_WR_I    = 4'd7,
    S_WR_J    = 4'd8,
    S_INC     = 4'd9,
    S_DONE    = 4'd10
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      i_q, i_d;
  logic [DATA_W-1:0]      j_q, j_d;
  logic [DATA_W-1:0]      si_q, si_d;
  logic [DATA_W-1:0]      sj_q, sj_d;
  logic [KIW-1:0]         kidx_q, kidx_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;

  logic [7:0]             key_slots [KSLOTS];
  logic [7:0]             key_byte;
  logic [DATA_W-1:0]      key_ext;

  // Split the latched key into bytes, byte 0 taken from the MSBs. The
  // clamped slice base keeps every unrolled select in range; slots past
  // KEY_BYTES are never addressed because the counter wraps first.
  always_comb begin
    for (int k = 0; k < KSLOTS; k++) begin
      key_slots[k] = 8'h00;
      if (k < KEY_BYTES) begin
        key_slots[k] = key_q[8*((k < KEY_BYTES) ? (KEY_BYTES-1-k) : 0) +: 8];
      end
    end
  end

  assign key_byte = key_slots[kidx_q];

  // Zero-extend (DATA_W > 8) or truncate (DATA_W < 8) the key byte.
  always_comb begin
    key_ext = '0;
    for (int b = 0; b < DATA_W; b++) begin
      if (b < 8) begin
        key_ext[b] = key_byte[(b < 8) ? b : 0];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    busy    = (state_q != S_IDLE);
    done    = 1'b0;
    wren    = 1'b0;
    address = '0;
    data    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          key_d   = secret_key;
          state_d = init_en ? S_INIT_WR : S_RD_I1;
        end
      end

      S_INIT_WR: begin
        wren    = 1'b1;
        address = i_q;
        data    = i_q;
        if (i_q == I_LAST) begin
          i_d     = '0;
          state_d = S_RD_I1;
        end else begin
          i_d = i_q + 1'b1;
        end
      end

      S_RD_I1: begin
        address = i_q;
        state_d = S_RD_I2;
      end

      S_RD_I2: begin
        address = i_q;
        si_d    = q;
        state_d = S_CALC_J;
      end

      S_CALC_J: begin
        address = i_q;
        j_d     = j_q + si_q + key_ext;
        state_d = S_RD_J1;
      end

      // j_q already holds the updated index here.
      S_RD_J1: begin
        address = j_q;
        state_d = S_RD_J2;
      end

      S_RD_J2: begin
        address = j_q;
        sj_d    = q;
        state_d = S_WR_I;
      end

      // Both writes happen even when i == j; they then store the same
      // value twice and the table is unchanged.
      S_WR_I: begin
        wren    = 1'b1;
        address = i_q;
        data    = sj_q;
        state_d = S_WR_J;
      end

      S_WR_J: begin
        wren    = 1'b1;
        address = j_q;
        data    = si_q;
        state_d = S_INC;
      end

      S_INC: begin
        if (i_q == I_LAST) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 1'b1;
          kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
          state_d = S_RD_I1;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_ksa_scrambler.sv
// Testbench for ksa_scrambler. Two instances share clock, reset, start and
// init_en: one with a 3-byte key, one with a 5-byte key. Each has its own
// single-port RAM with one cycle of read latency. Expected write traces and
// final tables come from a plain software KSA model.

module tb_ksa_scrambler;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic reset;
  logic start;
  logic init_en;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------- DUTs
  logic [23:0] key3;
  logic [39:0] key5;
  logic [7:0]  q3, q5, addr3, addr5, data3, data5;
  logic        busy3, done3, wren3, busy5, done5, wren5;
  logic [3:0]  st3, st5;

  ksa_scrambler #(.DATA_W(8), .KEY_BYTES(3)) u_dut3 (
    .clock(clock), .reset(reset), .start(start), .init_en(init_en),
    .secret_key(key3), .q(q3), .busy(busy3), .done(done3), .wren(wren3),
    .address(addr3), .data(data3), .state_dbg(st3)
  );

  ksa_scrambler #(.DATA_W(8), .KEY_BYTES(5)) u_dut5 (
    .clock(clock), .reset(reset), .start(start), .init_en(init_en),
    .secret_key(key5), .q(q5), .busy(busy5), .done(done5), .wren(wren5),
    .address(addr5), .data(data5), .state_dbg(st5)
  );

  // ---------------------------------------------------------------- RAM models
  logic [7:0] mem3 [256];
  logic [7:0] mem5 [256];

  always @(posedge clock) begin
    if (wren3) mem3[addr3] <= data3;
    q3 <= mem3[addr3];
  end

  always @(posedge clock) begin
    if (wren5) mem5[addr5] <= data5;
    q5 <= mem5[addr5];
  end

  // Every write of the 3-byte instance, as {address, data}.
  logic [15:0] got3_q [$];
  always @(negedge clock) begin
    if (wren3) got3_q.push_back({addr3, data3});
  end

  // ---------------------------------------------------------------- scoreboard
  logic [15:0] exp_q [$];
  logic [7:0]  work [256];
  logic [7:0]  ref3 [256];
  logic [7:0]  ref5 [256];
  int          base3;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Software KSA on work[]; optionally records the two writes per swap.
  task automatic ksa_model(input int kb, input logic [39:0] key, input bit log_w);
    int         j;
    logic [7:0] kbyte;
    logic [7:0] t;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kbyte = 8'(key >> (8 * (kb - 1 - (i % kb))));
      j = (j + int'(work[i]) + int'(kbyte)) % 256;
      if (log_w) begin
        exp_q.push_back({8'(i), work[j]});
        exp_q.push_back({8'(j), work[i]});
      end
      t       = work[i];
      work[i] = work[j];
      work[j] = t;
    end
  endtask

  task automatic prep_models(input bit ini, input logic [23:0] k3, input logic [39:0] k5);
    exp_q.delete();
    base3 = got3_q.size();
    for (int a = 0; a < 256; a++) begin
      work[a] = ini ? 8'(a) : mem3[a];
      if (ini) exp_q.push_back({8'(a), 8'(a)});
    end
    ksa_model(3, {16'h0000, k3}, 1'b1);
    for (int a = 0; a < 256; a++) ref3[a] = work[a];
    for (int a = 0; a < 256; a++) work[a] = ini ? 8'(a) : mem5[a];
    ksa_model(5, k5, 1'b0);
    for (int a = 0; a < 256; a++) ref5[a] = work[a];
  endtask

  task automatic finish_checks(input string name);
    int bad;
    int m3;
    int m5;
    bad = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base3 + k >= got3_q.size() || got3_q[base3 + k] !== exp_q[k]) begin
        bad = k;
        break;
      end
    end
    check({name, "_trace_len"}, got3_q.size() - base3, exp_q.size());
    check({name, "_trace_first_bad_idx"}, bad, -1);
    m3 = 0;
    m5 = 0;
    for (int a = 0; a < 256; a++) begin
      if (mem3[a] !== ref3[a]) m3++;
      if (mem5[a] !== ref5[a]) m5++;
    end
    check({name, "_table3_mismatches"}, m3, 0);
    check({name, "_table5_mismatches"}, m5, 0);
  endtask

  // Called at the negedge after the accepting edge. Counts edges until
  // done; also disturbs inputs mid-run and can pulse / hold start.
  task automatic wait_done(input int pulse_at, input int hold_from,
                           output int lat, output bit busy_ok, output bit d5_ok);
    lat     = -1;
    busy_ok = 1'b1;
    d5_ok   = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clock);
      #1;
      if (done3) begin
        lat = n;
        if (!done5) d5_ok = 1'b0;
        break;
      end
      if (!busy3 || !busy5 || done5) busy_ok = 1'b0;
      if (n == 5) begin
        key3    = 24'($urandom);
        key5    = {8'($urandom), 32'($urandom)};
        init_en = ~init_en;
      end
      if (n == pulse_at) start = 1'b1;
      else if (n == pulse_at + 1) start = 1'b0;
      if (n == hold_from) init_en = 1'b1;
      if (n >= hold_from) start = 1'b1;
    end
  endtask

  task automatic run_check(input string name, input bit ini, input logic [23:0] k3,
                           input logic [39:0] k5, input int exp_lat);
    int lat;
    bit bok;
    bit d5;
    prep_models(ini, k3, k5);
    @(negedge clock);
    init_en = ini;
    key3    = k3;
    key5    = k5;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    wait_done(-1, 1 << 30, lat, bok, d5);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_throughout"}, bok, 1);
    check({name, "_done5_same_cycle"}, d5, 1);
    @(posedge clock);
    #1;
    check({name, "_done_single_pulse"}, {done3, busy3}, 0);
    @(negedge clock);
    finish_checks(name);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit          ini;
    logic [23:0] k3;
    logic [39:0] k5;
    int          exp_lat;
    int          nw;
    logic [15:0] w [6];
  } vec_t;

  vec_t vecs [3];

  initial begin
    int          lat;
    int          off;
    int          sz;
    bit          bok;
    bit          d5;
    bit          ini;
    logic [23:0] rk3;
    logic [39:0] rk5;

    vecs[0].ini = 1'b1; vecs[0].k3 = 24'h010203; vecs[0].k5 = 40'h0102030405;
    vecs[0].exp_lat = 2304; vecs[0].nw = 6;
    vecs[0].w = '{16'h0001, 16'h0100, 16'h0103, 16'h0300, 16'h0208, 16'h0802};
    vecs[1].ini = 1'b1; vecs[1].k3 = 24'h000000; vecs[1].k5 = 40'h0000000000;
    vecs[1].exp_lat = 2304; vecs[1].nw = 6;
    vecs[1].w = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
    vecs[2].ini = 1'b0; vecs[2].k3 = 24'hFFFFFF; vecs[2].k5 = 40'hA55AC33C0F;
    vecs[2].exp_lat = 2048; vecs[2].nw = 0;
    vecs[2].w = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

    // Reset state.
    reset = 1'b1; start = 1'b0; init_en = 1'b0; key3 = '0; key5 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy3, 0);
    check("rst_done", done3, 0);
    check("rst_wren", wren3, 0);
    check("rst_address", addr3, 0);
    check("rst_data", data3, 0);
    check("rst_state", st3, 0);
    check("rst_busy5", busy5, 0);
    @(negedge clock);
    reset = 1'b0;

    // Table-driven runs.
    for (int v = 0; v < 3; v++) begin
      run_check($sformatf("vec%0d", v), vecs[v].ini, vecs[v].k3, vecs[v].k5, vecs[v].exp_lat);
      off = vecs[v].ini ? 256 : 0;
      for (int n = 0; n < vecs[v].nw; n++) begin
        check($sformatf("vec%0d_swap_write%0d", v, n), got3_q[base3 + off + n], vecs[v].w[n]);
      end
    end

    // Randomized runs.
    for (int r = 0; r < 3; r++) begin
      ini = 1'($urandom_range(0, 1));
      rk3 = 24'($urandom);
      rk5 = {8'($urandom), 32'($urandom)};
      run_check($sformatf("rand%0d", r), ini, rk3, rk5, ini ? 2304 : 2048);
    end

    // Reset in the middle of a run.
    @(negedge clock);
    init_en = 1'b0; key3 = 24'($urandom); key5 = {8'($urandom), 32'($urandom)}; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (99) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_busy", busy3, 0);
    check("midrst_wren", wren3, 0);
    check("midrst_done", done3, 0);
    check("midrst_address", addr3, 0);
    check("midrst_busy5", busy5, 0);
    sz = got3_q.size();
    @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("midrst_no_more_writes", got3_q.size() - sz, 0);
    run_check("post_rst", 1'b0, 24'($urandom), {8'($urandom), 32'($urandom)}, 2048);

    // start pulsed while busy, then held high through DONE.
    rk3 = 24'($urandom);
    rk5 = {8'($urandom), 32'($urandom)};
    prep_models(1'b1, rk3, rk5);
    @(negedge clock);
    init_en = 1'b1; key3 = rk3; key5 = rk5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(50, 2200, lat, bok, d5);
    check("hold_run1_latency", lat, 2304);
    check("hold_run1_busy_throughout", bok, 1);
    @(posedge clock);
    #1;
    check("hold_idle_busy", busy3, 0);
    check("hold_idle_done", done3, 0);
    finish_checks("hold_run1");
    prep_models(1'b1, key3, key5);
    @(posedge clock);
    #1;
    check("hold_restart_busy", busy3, 1);
    @(negedge clock);
    start = 1'b0;
    wait_done(-1, 1 << 30, lat, bok, d5);
    check("hold_run2_latency", lat, 2304);
    check("hold_run2_busy_throughout", bok, 1);
    @(posedge clock);
    #1;
    check("hold_run2_done_single_pulse", {done3, busy3}, 0);
    @(negedge clock);
    finish_checks("hold_run2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ksa_scrambler.md
KSA_SCRAMBLER -- requirements
Module: ksa_scrambler

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning symbol/address width; table depth DEPTH = 2**DATA_W.
REQ-002 SHALL have parameter KEY_BYTES, default 3, meaning secret key length in bytes (range 1..32).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clock  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  request to begin; sampled only in IDLE.
REQ-007 SHALL have port init_en  in  1  when 1 at start, fill s[a]=a for all a before scrambling.
REQ-008 SHALL have port secret_key  in  KEY_BYTES*8  key; byte k = secret_key[(KEY_BYTES-1-k)*8 +: 8] (byte 0 = MSB).
REQ-009 SHALL have port q  in  DATA_W  RAM read data.
REQ-010 SHALL have port busy  out  1  high in every non-IDLE state.
REQ-011 SHALL have port done  out  1  one-cycle pulse on completion.
REQ-012 SHALL have port wren  out  1  RAM write enable.
REQ-013 SHALL have port address  out  DATA_W  RAM address.
REQ-014 SHALL have port data  out  DATA_W  RAM write data.

Function
REQ-015 SHALL compute j=0; for i in 0..DEPTH-1: j=(j+s[i]+key[i mod KEY_BYTES]) mod DEPTH; swap(s[i],s[j]), all DEPTH entries processed.
REQ-016 SHALL latch secret_key and init_en on the accepting start edge; later changes have no effect until next start.
REQ-017 SHALL track i mod KEY_BYTES with a wrapping key-index counter reset to 0 with i (no divider).
REQ-018 SHALL use key byte zero-extended or truncated to DATA_W; all sums mod 2**DATA_W.
REQ-019 SHALL treat RAM read as: address held two cycles, q captured at end of second cycle.
REQ-020 SHALL implement states IDLE, INIT_WR, RD_I1, RD_I2, CALC_J, RD_J1, RD_J2, WR_I, WR_J, INC, DONE.
REQ-021 IDLE: start=1 -> INIT_WR if init_en else RD_I1; i, j, key index cleared to 0.
REQ-022 INIT_WR: wren=1, address=i, data=i; i==DEPTH-1 -> i=0, RD_I1; else i+1, stay.
REQ-023 RD_I1/RD_I2: address=i; si<=q at end of RD_I2.
REQ-024 CALC_J: j<=j+si+key[k]; address=i, wren=0.
REQ-025 RD_J1/RD_J2: address=j (new value); sj<=q at end of RD_J2.
REQ-026 WR_I: wren=1, address=i, data=sj; WR_J: wren=1, address=j, data=si.
REQ-027 INC: i==DEPTH-1 -> DONE; else i+1, key index wraps at KEY_BYTES-1 -> 0, -> RD_I1.
REQ-028 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-029 i==j SHALL still perform both writes (same value twice; table unchanged).
REQ-030 Latency SHALL be: first done cycle = 8*DEPTH cycles after accepting edge, plus DEPTH when init_en=1.
REQ-031 start while busy SHALL be ignored; start held high in DONE->IDLE re-triggers on next IDLE edge.
REQ-032 wren SHALL be 0 in all states other than INIT_WR, WR_I, WR_J.
REQ-033 address and data SHALL be 0 in IDLE and DONE.

Reset
REQ-034 reset=1 SHALL force IDLE at next edge from any state, overriding start.
REQ-035 After reset: busy=0, done=0, wren=0, address=0, data=0, i=j=si=sj=0, key index=0.
REQ-036 Reset mid-operation SHALL abort without further writes; table left partially scrambled.

Verification
REQ-037 Reset, init_en=1, key=0x010203, start -> DEPTH init writes addr a data a, then first swap writes (addr 0,data 1),(addr 1,data 0).
REQ-038 Same run -> done single pulse at cycle 8*256+256=2304 after start edge; RAM model equals software KSA for key 01 02 03.
REQ-039 init_en=1, key=0x000000 -> i=0,1 writes equal existing values (i==j); i=2 j=3 writes (addr 2,data 3),(addr 3,data 2).
REQ-040 KEY_BYTES=5, DATA_W=8, key=0x0102030405 -> key index wraps after 5; final table matches software model.
REQ-041 reset asserted at cycle 100 of a run -> next cycle IDLE, wren=0, busy=0; new start completes correctly.
REQ-042 start pulsed while busy and held high through DONE -> no restart mid-run; second run begins in cycle after IDLE.
